hmac_stream_arbiter: RTL and testbench
======================================

Name: hmac_stream_arbiter

Overview:
- Shares one HMAC/SHA engine between N_REQ AXI-stream requesters, with packet-granular round-robin arbitration.
- Forwards whole packets from the granted requester to the engine input, recording the grant index in a tag FIFO.
- Steers each digest packet returned by the engine back to the requester at the FIFO head, so digests return in grant order.
- Sits upstream of the last-beat-replacement stage: requester r_* ports feed that stage's check input.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 512, stream data width; keep width is DATA_W/8
- TAG_DEPTH, 4, max packets granted but whose digest has not yet returned (power of 2)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low reset
- s_valid  in  N_REQ  per-requester input valid
- s_ready  out  N_REQ  per-requester input ready
- s_data  in  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- s_keep  in  N_REQ*DATA_W/8  packed per requester, same layout
- s_id  in  N_REQ*6  packed per requester, same layout
- s_last  in  N_REQ  end of packet
- m_valid / m_ready  out / in  1  engine input handshake
- m_data / m_keep / m_id / m_last  out  DATA_W / DATA_W/8 / 6 / 1  engine input payload
- d_valid / d_ready  in / out  1  engine digest return handshake
- d_data / d_keep / d_id / d_last  in  DATA_W / DATA_W/8 / 6 / 1  digest payload
- r_valid  out  N_REQ  digest valid to requester
- r_ready  in  N_REQ  digest ready from requester
- r_data / r_keep / r_id / r_last  out  DATA_W / DATA_W/8 / 6 / 1  shared digest payload, qualified by r_valid
- grant_active  out  1  high in PASS
- grant_idx  out  clog2(N_REQ)  current or last grant
- pending  out  clog2(TAG_DEPTH)+1  tag FIFO occupancy

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM to IDLE; rr_ptr=0; grant_idx=0.
  - Tag FIFO read/write pointers and count = 0.
  - Consequently, all valid/ready outputs are 0, pending=0, grant_active=0.
  - A reset mid-packet abandons the packet; no partial state survives.
- FSM IDLE:
  - Grant condition: any s_valid set and pending<TAG_DEPTH.
  - Pick the first set s_valid scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - On a grant, register grant_idx, push grant_idx into the tag FIFO and go to PASS.
  - All s_ready=0 and m_valid=0 in IDLE, so arbitration costs exactly 1 bubble cycle per packet.
- FSM PASS, with g = grant_idx:
  - Engine side: m_valid=s_valid[g]; m_data/m_keep/m_id/m_last are requester g's fields.
  - s_ready[g]=m_ready; every other s_ready=0.
  - Handshake with s_last[g]: rr_ptr <= (g+1) mod N_REQ, next state IDLE.
  - No mid-packet preemption; the grant persists across stalls of any length.
- Tag FIFO full (pending==TAG_DEPTH): IDLE grants nothing; the current PASS packet still completes.
- Digest routing is independent of the FSM and runs concurrently:
  - FIFO empty: d_ready=0, r_valid=0.
  - Otherwise, h = FIFO head: r_valid[h]=d_valid, d_ready=r_ready[h], other r_valid=0.
  - r_data/r_keep/r_id/r_last = d_* unmodified and combinational, with zero added latency.
  - The FIFO pops on d_valid&&d_ready&&d_last.
- Simultaneous push and pop: pending unchanged, both pointers advance, head/tail order preserved.
- Pointer wrap: pointers wrap modulo TAG_DEPTH.
- Handshake rules: no combinational path from any s_valid to s_ready (s_ready depends only on state, g and m_ready).
- Unused payload: output payload fields are 0 when the corresponding valid is 0.

Test Plan:
- Single requester: req 0 sends a 3-beat packet, m_ready=1 → beats appear on m_* on cycles 1–3 after s_valid[0] rises; pending goes 0→1; then a 1-beat digest on d_* → r_valid[0] pulses, pending returns to 0.
- Fairness: reqs 0, 1 and 3 hold continuous 2-beat packets → grant order 0,1,3,0,1,3; each packet is separated by exactly one idle cycle on m_valid.
- Backpressure: m_ready toggles every cycle mid-packet, and req 2 asserts valid meanwhile → req 2 is not granted until the current last beat is accepted; no beat is lost or duplicated (check by data counter pattern).
- Full FIFO: TAG_DEPTH=4, four packets are granted with no digests returned → a fifth s_valid sees s_ready=0 and grant_active=0. Returning one digest → grant resumes in the following IDLE cycle.
- Routing and simultaneity: grants 2 then 0, with a digest last beat accepted in the same cycle as a new grant → digests arrive at r_valid[2] then r_valid[0]; pending stays constant on the push+pop cycle. With r_ready[2]=0, d_ready=0.
- Reset mid-packet: assert reset during beat 2 of a 4-beat packet with pending=2 → the next cycle shows all valid/ready 0, pending=0, rr_ptr=0; afterwards a fresh request from req 1 is granted normally.

Source files
------------

// File: rtl/hmac_stream_arbiter.sv
// hmac_stream_arbiter: shares one HMAC/SHA engine between N_REQ AXI-stream
// requesters. Whole packets are granted round-robin, the grant index is
// queued in a tag FIFO, and each returning digest packet is steered to the
// requester at the FIFO head so digests come back in grant order.
module hmac_stream_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 512,
  parameter int TAG_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  s_valid,
  output logic [N_REQ-1:0]                  s_ready,
  input  logic [N_REQ*DATA_W-1:0]           s_data,
  input  logic [N_REQ*(DATA_W/8)-1:0]       s_keep,
  input  logic [N_REQ*6-1:0]                s_id,
  input  logic [N_REQ-1:0]                  s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_W-1:0]                 m_data,
  output logic [DATA_W/8-1:0]               m_keep,
  output logic [5:0]                        m_id,
  output logic                              m_last,
  input  logic                              d_valid,
  output logic                              d_ready,
  input  logic [DATA_W-1:0]                 d_data,
  input  logic [DATA_W/8-1:0]               d_keep,
  input  logic [5:0]                        d_id,
  input  logic                              d_last,
  output logic [N_REQ-1:0]                  r_valid,
  input  logic [N_REQ-1:0]                  r_ready,
  output logic [DATA_W-1:0]                 r_data,
  output logic [DATA_W/8-1:0]               r_keep,
  output logic [5:0]                        r_id,
  output logic                              r_last,
  output logic                              grant_active,
  output logic [$clog2(N_REQ)-1:0]          grant_idx,
  output logic [$clog2(TAG_DEPTH):0]        pending
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_REQ);
  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [IDX_W-1:0]   tag_mem_r [TAG_DEPTH];

  logic [DATA_W-1:0]  s_data_a [N_REQ];
  logic [KEEP_W-1:0]  s_keep_a [N_REQ];
  logic [5:0]         s_id_a   [N_REQ];

  logic [IDX_W-1:0]   pick_s;
  logic [IDX_W-1:0]   head_s;
  logic               empty_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic               last_hs_s;

  // First requester with valid set, scanning from ptr upward modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      sel = IDX_W'(idx);
      if (!found && req[sel]) begin
        pick  = sel;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Slice the packed requester buses into per-requester lanes.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign s_data_a[gi] = s_data[gi*DATA_W +: DATA_W];
    assign s_keep_a[gi] = s_keep[gi*KEEP_W +: KEEP_W];
    assign s_id_a[gi]   = s_id[gi*6 +: 6];
  end

  assign pick_s    = rr_pick(s_valid, rr_ptr_r);
  assign empty_s   = (count_r == CNT_W'(0));
  assign full_s    = (count_r == CNT_W'(TAG_DEPTH));
  assign head_s    = tag_mem_r[rd_ptr_r];
  assign push_s    = (state_r == ST_IDLE) && (|s_valid) && !full_s;
  assign pop_s     = d_valid && d_ready && d_last;
  assign last_hs_s = (state_r == ST_PASS) && s_valid[grant_idx_r] && m_ready
                     && s_last[grant_idx_r];

  assign grant_active = (state_r == ST_PASS);
  assign grant_idx    = grant_idx_r;
  assign pending      = count_r;

  // Engine-side forwarding: connect the granted requester while in PASS.
  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_keep  = '0;
    m_id    = 6'd0;
    m_last  = 1'b0;
    if (state_r == ST_PASS) begin
      s_ready[grant_idx_r] = m_ready;
      if (s_valid[grant_idx_r]) begin
        m_valid = 1'b1;
        m_data  = s_data_a[grant_idx_r];
        m_keep  = s_keep_a[grant_idx_r];
        m_id    = s_id_a[grant_idx_r];
        m_last  = s_last[grant_idx_r];
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      s_ready = '0;
    end
  end

  // Digest steering: route the engine's digest to the FIFO-head requester.
  always_comb begin
    r_valid = '0;
    d_ready = 1'b0;
    r_data  = '0;
    r_keep  = '0;
    r_id    = 6'd0;
    r_last  = 1'b0;
    if (!empty_s) begin
      r_valid[head_s] = d_valid;
      d_ready         = r_ready[head_s];
      if (d_valid) begin
        r_data = d_data;
        r_keep = d_keep;
        r_id   = d_id;
        r_last = d_last;
      end else begin
        r_last = 1'b0;
      end
    end else begin
      d_ready = 1'b0;
    end
  end

  // Arbitration FSM: grant a whole packet, hold it until its last beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_idx_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (push_s) begin
            grant_idx_r <= pick_s;
            state_r     <= ST_PASS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PASS: begin
          if (last_hs_s) begin
            rr_ptr_r <= (grant_idx_r == IDX_W'(N_REQ - 1)) ? '0
                        : grant_idx_r + IDX_W'(1);
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_PASS;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy; push on grant, pop on digest last beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Tag FIFO storage: the granted index is written at the tail.
  always_ff @(posedge clock) begin
    if (reset && push_s) begin
      tag_mem_r[wr_ptr_r] <= pick_s;
    end
  end

endmodule

// File: tb/tb_hmac_stream_arbiter.sv
// Randomized self-checking bench for hmac_stream_arbiter with a queue-based
// reference model of packet arbitration and in-order digest return.
module tb_hmac_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int TD = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      s_valid, s_ready, s_last;
  logic [N*DW-1:0]   s_data;
  logic [N*KW-1:0]   s_keep;
  logic [N*6-1:0]    s_id;
  logic              m_valid, m_ready, m_last;
  logic [DW-1:0]     m_data;
  logic [KW-1:0]     m_keep;
  logic [5:0]        m_id;
  logic              d_valid, d_ready, d_last;
  logic [DW-1:0]     d_data;
  logic [KW-1:0]     d_keep;
  logic [5:0]        d_id;
  logic [N-1:0]      r_valid, r_ready;
  logic [DW-1:0]     r_data;
  logic [KW-1:0]     r_keep;
  logic [5:0]        r_id;
  logic              r_last;
  logic              grant_active;
  logic [1:0]        grant_idx;
  logic [2:0]        pending;

  hmac_stream_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
    .s_id(s_id), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_id(m_id), .m_last(m_last),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_keep(d_keep),
    .d_id(d_id), .d_last(d_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_keep(r_keep),
    .r_id(r_id), .r_last(r_last),
    .grant_active(grant_active), .grant_idx(grant_idx), .pending(pending)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Per-requester packet generators.
  bit          g_act  [N];
  int          g_left [N];
  int          g_seq  [N];
  logic [DW-1:0] g_data [N];
  logic [KW-1:0] g_keep [N];
  logic [5:0]    g_id   [N];

  // Reference model: one owner at a time, round-robin pointer, tag queue.
  bit m_busy;
  int m_owner, m_rr, m_gidx;
  int tagq[$];

  task automatic new_beat(input int i);
    g_data[i] = {8'(i), 24'(g_seq[i])};
    g_seq[i]++;
    g_keep[i] = KW'($urandom);
    g_id[i]   = 6'($urandom);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_rr = 0; m_gidx = 0;
    tagq.delete();
    for (int i = 0; i < N; i++) g_act[i] = 1'b0;
  endtask

  initial begin
    logic [N-1:0]  e_sready, e_rvalid;
    logic          e_mvalid, e_dready;
    logic [DW-1:0] e_mdata, e_rdata;
    logic [KW-1:0] e_mkeep, e_rkeep;
    logic [5:0]    e_mid, e_rid;
    logic          e_mlast, e_rlast;
    bit hs, done, pop, grant;
    int pick, h, dprob;

    reset = 1'b0;
    s_valid = '0; s_last = '0; s_data = '0; s_keep = '0; s_id = '0;
    m_ready = 1'b0; d_valid = 1'b0; d_last = 1'b0; d_data = '0;
    d_keep = '0; d_id = '0; r_ready = '0;
    for (int i = 0; i < N; i++) begin
      g_seq[i] = 0; g_left[i] = 0; new_beat(i);
    end
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("rst_grant_active", 64'(grant_active), 64'(0));
    check_val("rst_pending", 64'(pending), 64'(0));
    check_val("rst_grant_idx", 64'(grant_idx), 64'(0));
    check_val("rst_s_ready", 64'(s_ready), 64'(0));
    check_val("rst_m_valid", 64'(m_valid), 64'(0));
    check_val("rst_d_ready", 64'(d_ready), 64'(0));
    check_val("rst_r_valid", 64'(r_valid), 64'(0));

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge clock);
      reset = !(cyc == 1700 || cyc == 2400);
      for (int i = 0; i < N; i++) begin
        if (!g_act[i] && ($urandom % 10) < 3) begin
          g_act[i]  = 1'b1;
          g_left[i] = 1 + int'($urandom % 4);
          new_beat(i);
        end
        s_valid[i]          = g_act[i];
        s_last[i]           = g_act[i] && (g_left[i] == 1);
        s_data[i*DW +: DW]  = g_data[i];
        s_keep[i*KW +: KW]  = g_keep[i];
        s_id[i*6 +: 6]      = g_id[i];
      end
      m_ready = (($urandom % 10) < 7);
      r_ready = N'($urandom);
      dprob   = ((cyc % 500) < 120) ? 3 : 55;
      d_valid = (int'($urandom % 100) < dprob);
      d_data  = DW'($urandom);
      d_keep  = KW'($urandom);
      d_id    = 6'($urandom);
      d_last  = 1'($urandom);
      #1;

      // Expected outputs from the model.
      e_sready = '0; e_mvalid = 1'b0; e_mdata = '0; e_mkeep = '0;
      e_mid = '0; e_mlast = 1'b0;
      if (m_busy) begin
        e_sready[m_owner] = m_ready;
        if (g_act[m_owner]) begin
          e_mvalid = 1'b1; e_mdata = g_data[m_owner];
          e_mkeep = g_keep[m_owner]; e_mid = g_id[m_owner];
          e_mlast = (g_left[m_owner] == 1);
        end
      end
      e_rvalid = '0; e_dready = 1'b0; e_rdata = '0; e_rkeep = '0;
      e_rid = '0; e_rlast = 1'b0; h = -1;
      if (tagq.size() > 0) begin
        h = tagq[0];
        e_rvalid[h] = d_valid;
        e_dready = r_ready[h];
        if (d_valid) begin
          e_rdata = d_data; e_rkeep = d_keep; e_rid = d_id; e_rlast = d_last;
        end
      end

      check_val("s_ready", 64'(s_ready), 64'(e_sready));
      check_val("m_valid", 64'(m_valid), 64'(e_mvalid));
      check_val("m_data", 64'(m_data), 64'(e_mdata));
      check_val("m_keep", 64'(m_keep), 64'(e_mkeep));
      check_val("m_id", 64'(m_id), 64'(e_mid));
      check_val("m_last", 64'(m_last), 64'(e_mlast));
      check_val("r_valid", 64'(r_valid), 64'(e_rvalid));
      check_val("d_ready", 64'(d_ready), 64'(e_dready));
      check_val("r_data", 64'(r_data), 64'(e_rdata));
      check_val("r_keep", 64'(r_keep), 64'(e_rkeep));
      check_val("r_id", 64'(r_id), 64'(e_rid));
      check_val("r_last", 64'(r_last), 64'(e_rlast));
      check_val("grant_active", 64'(grant_active), 64'(m_busy));
      check_val("grant_idx", 64'(grant_idx), 64'(m_gidx));
      check_val("pending", 64'(pending), 64'(tagq.size()));

      // Advance the model to the state after this clock edge.
      hs   = m_busy && g_act[m_owner] && m_ready;
      done = hs && (g_left[m_owner] == 1);
      pop  = (h >= 0) && d_valid && r_ready[h] && d_last;
      grant = 1'b0; pick = 0;
      if (!m_busy && tagq.size() < TD) begin
        for (int k = 0; k < N; k++) begin
          if (!grant && g_act[(m_rr + k) % N]) begin
            grant = 1'b1; pick = (m_rr + k) % N;
          end
        end
      end
      if (!reset) begin
        model_reset();
      end else begin
        if (hs) begin
          if (done) begin
            g_act[m_owner] = 1'b0;
            m_busy = 1'b0;
            m_rr = (m_owner + 1) % N;
          end else begin
            g_left[m_owner]--;
            new_beat(m_owner);
          end
        end
        if (pop) void'(tagq.pop_front());
        if (grant) begin
          m_busy = 1'b1; m_owner = pick; m_gidx = pick;
          tagq.push_back(pick);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
